// File: rtl/riscv_m_pkg.sv
// Shared constants and types for the RV32M multiply/divide execute unit.
package riscv_m_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  // funct7 value identifying an OP-class instruction as M-extension
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring trial-subtract for divide. acc holds {hi, lo} halves.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   mcand,
  input  logic              mul_bit,
  input  logic [XLEN-1:0]   divisor,
  input  logic              div_bit,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;

  // Single-step combinational update of the accumulator
  always_comb begin
    hi     = acc_in[2*XLEN-1:XLEN];
    lo     = acc_in[XLEN-1:0];
    sum    = {1'b0, hi} + (mul_bit ? {1'b0, mcand} : '0);
    rem_sh = {hi, div_bit};
    // Partial remainder is always below the divisor, so bit XLEN of the
    // difference is set exactly when the trial subtraction underflows.
    trial  = rem_sh - {1'b0, divisor};
    if (is_div) begin
      if (!trial[XLEN]) acc_out = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else              acc_out = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_out = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, sign-magnitude
// operands, sign fix-up in a dedicated state, divide special cases in IDLE.
module riscv_muldiv
  import riscv_m_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              sa_q, sa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic              a_sgn, b_sgn, div_zero, ovf;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (f3_q[2]),
    .acc_in  (acc_q),
    .mcand   (opa_q),
    .mul_bit (opb_q[0]),
    .divisor (opb_q),
    .div_bit (opa_q[XLEN-1]),
    .acc_out (step_acc)
  );

  // Next-state, datapath sequencing and result selection
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    a_sgn    = srcA[XLEN-1] & (funct3 inside {MULH_F3, MULHSU_F3, DIV_F3, REM_F3});
    b_sgn    = srcB[XLEN-1] & (funct3 inside {MULH_F3, DIV_F3, REM_F3});
    a_mag    = a_sgn ? -srcA : srcA;
    b_mag    = b_sgn ? -srcB : srcB;
    div_zero = funct3[2] && (srcB == '0);
    ovf      = (funct3 == DIV_F3 || funct3 == REM_F3) && (srcA == MIN_NEG) && (srcB == '1);

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          f3_d  = funct3;
          neg_d = a_sgn ^ b_sgn;
          sa_d  = a_sgn;
          opa_d = a_mag;
          opb_d = b_mag;
          acc_d = '0;
          cnt_d = '0;
          if (div_zero) begin
            result_d = funct3[1] ? srcA : '1;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = funct3[1] ? '0 : srcA;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (f3_q[2]) opa_d = opa_q << 1;
        else         opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      end
      FIX: begin
        unique case (f3_q)
          MUL_F3:                      result_d = prod[XLEN-1:0];
          MULH_F3, MULHSU_F3, MULHU_F3: result_d = prod[2*XLEN-1:XLEN];
          DIV_F3, DIVU_F3:             result_d = neg_q ? -quo : quo;
          default:                     result_d = sa_q ? -rem : rem;
        endcase
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush wins over everything except reset; the result is left untouched.
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: cycle-level behavioural model plus
// directed scenarios with hand-computed expectations and random traffic.
module tb_riscv_muldiv;

  localparam int XLEN = 32;
  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  riscv_muldiv #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib, iq;
    ia = a;
    ib = b;
    case (f3)
      F_MUL:    begin p = longint'(ia) * longint'(ib); return p[31:0]; end
      F_MULH:   begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      F_MULHSU: begin p = longint'(ia) * longint'({32'h0, b}); return p[63:32]; end
      F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        iq = ia / ib; return iq;
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        iq = ia % ib; return iq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) || ((f3 == F_DIV || f3 == F_REM) && a == MINV && b == 32'hFFFF_FFFF);
  endfunction

  // Cycle-level model: one op in flight, outputs derived from accept edge
  int          cyc = 0;
  bit          armed = 0;
  bit          pend = 0;
  int          done_e = 0;
  logic [31:0] pres = '0;
  logic [31:0] exp_res = '0;
  bit          exp_busy = 0, exp_done = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend = 0; exp_res = '0; armed = 1;
    end else if (kill) begin
      pend = 0;
    end else begin
      if (!pend) begin
        if (start) begin
          pend   = 1;
          done_e = cyc + (is_special(funct3, srcA, srcB) ? 0 : XLEN + 1);
          pres   = ref_op(funct3, srcA, srcB);
        end
      end else if (cyc == done_e + 1) begin
        pend = 0;
      end
      if (pend && cyc == done_e) exp_res = pres;
    end
    exp_busy = pend;
    exp_done = pend && (cyc == done_e);
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, exp_busy});
      check("cyc_done", {31'b0, done}, {31'b0, exp_done});
      check("cyc_result", result, exp_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble operands afterwards, wait (bounded) for done
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    bit got;
    funct3 = f3; srcA = a; srcB = b; start = 1'b1;
    tick();
    start = 1'b0; funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
    n = 1; got = 0;
    while (n <= 60) begin
      if (done) begin got = 1; break; end
      tick(); n++;
    end
    if (!got) begin
      check({name, "_timeout"}, 32'(n), 32'(exp_lat));
    end else begin
      check({name, "_result"}, result, exp);
      check({name, "_latency"}, 32'(n), 32'(exp_lat));
    end
    tick();
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 5))
      0: return MINV;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, ndone;
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);

    // Pin the reference model with hand-computed values
    check("ref_mul",    ref_op(F_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("ref_mulh",   ref_op(F_MULH, MINV, MINV), 32'h4000_0000);
    check("ref_mulhu",  ref_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("ref_mulhsu", ref_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("ref_div",    ref_op(F_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("ref_rem",    ref_op(F_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("ref_divu",   ref_op(F_DIVU, 32'd100, 32'd7), 32'd14);
    check("ref_remu",   ref_op(F_REMU, 32'd100, 32'd7), 32'd2);

    // Directed operations from the plan
    run_op("mul",    F_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",   F_MULH,   MINV, MINV, 32'h4000_0000, 34);
    run_op("mulhu",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("divu",   F_DIVU,   32'd100, 32'd7, 32'd14, 34);
    run_op("remu",   F_REMU,   32'd100, 32'd7, 32'd2, 34);
    run_op("div",    F_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem",    F_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("div0",   F_DIV,    32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem0",   F_REM,    32'd5, 32'd0, 32'd5, 1);
    run_op("divovf", F_DIV,    MINV, 32'hFFFF_FFFF, MINV, 1);
    run_op("removf", F_REM,    MINV, 32'hFFFF_FFFF, 32'h0, 1);

    // Kill at cycle 10 of a DIVU; previous result (0) must survive
    funct3 = F_DIVU; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    kill = 1'b1;
    tick(); kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'h0);
    check("kill_done", {31'b0, done}, 32'h0);
    check("kill_result", result, 32'h0);
    run_op("after_kill", F_DIVU, 32'd1000, 32'd3, 32'd333, 34);

    // Spurious start at cycle 5 of a MUL is ignored
    funct3 = F_MUL; srcA = 32'd12; srcB = 32'd11; start = 1'b1;
    tick(); start = 1'b0;
    n = 1; ndone = 0;
    while (n <= 80) begin
      if (n == 4) begin funct3 = F_MUL; srcA = 32'd3; srcB = 32'd3; start = 1'b1; end
      else start = 1'b0;
      if (done) begin
        ndone++;
        check("spur_result", result, 32'd132);
        check("spur_latency", 32'(n), 32'd34);
      end
      tick(); n++;
    end
    check("spur_done_count", 32'(ndone), 32'd1);

    // Reset at cycle 20 of a MUL
    funct3 = F_MUL; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 2; i <= 20; i++) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    check("rst_no_done", 32'(ndone), 32'd0);

    // Random traffic: starts, flushes, occasional resets
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      funct3 = 3'($urandom);
      srcA   = pick_a();
      srcB   = pick_b();
      kill   = ($urandom_range(0, 69) == 0);
      reset  = ($urandom_range(0, 399) == 0);
      tick();
    end
    start = 1'b0; kill = 1'b0; reset = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
